// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register offsets and address-decode helpers for the GPIO bank
package gpio_pkg;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;
    localparam int OFF_STRIDE = 8;

    localparam logic [2:0] OFF_IN      = 3'd0;
    localparam logic [2:0] OFF_OUT     = 3'd1;
    localparam logic [2:0] OFF_DIR     = 3'd2;
    localparam logic [2:0] OFF_RISE_EN = 3'd3;
    localparam logic [2:0] OFF_FALL_EN = 3'd4;
    localparam logic [2:0] OFF_PEND    = 3'd5;
    localparam logic [2:0] OFF_SET     = 3'd6;
    localparam logic [2:0] OFF_CLR     = 3'd7;

    // IRQ_STAT sits directly after the last port window
    function automatic int irq_stat_index(input int n_ports);
        return n_ports * OFF_STRIDE;
    endfunction

    function automatic logic port_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input int p);
        int lo;
        lo = int'(base) + p * OFF_STRIDE;
        return (int'(addr) >= lo) && (int'(addr) < lo + OFF_STRIDE);
    endfunction

    function automatic logic irq_stat_hit(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base,
                                          input int n_ports);
        return int'(addr) == int'(base) + irq_stat_index(n_ports);
    endfunction

endpackage

// File: rtl/gpio_irq_bank_if.sv
// rtl/gpio_irq_bank_if.sv - CPU IO bus bundle between the bus master and the GPIO bank
interface gpio_irq_bank_if;
    import gpio_pkg::*;

    logic              CS;
    logic [ADDR_W-1:0] adresse;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] DATAout;
    logic [DATA_W-1:0] DATAin;

    modport master (output CS, adresse, write, read, DATAout, input DATAin);
    modport slave  (input CS, adresse, write, read, DATAout, output DATAin);
endinterface

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - one GPIO port: input sync, edge detect, pending bits and its registers
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad,
    input  logic             wr_en,
    input  logic [2:0]       off,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_val,
    output logic [WIDTH-1:0] out_val,
    output logic [WIDTH-1:0] dir_val,
    output logic             pend_any
);

    logic [WIDTH-1:0] s1, s2, prev;
    logic [WIDTH-1:0] out_q, dir_q, rise_en, fall_en, pend;
    logic [WIDTH-1:0] new_pend, clr_mask;

    assign new_pend = (s2 & ~prev & rise_en) | (~s2 & prev & fall_en);
    assign clr_mask = (wr_en && off == OFF_PEND) ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            prev    <= '0;
            out_q   <= '0;
            dir_q   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
        end else begin
            s1   <= pad;
            s2   <= s1;
            prev <= s2;
            // a fresh edge beats a same-cycle write-1-to-clear
            pend <= (pend & ~clr_mask) | new_pend;
            if (wr_en) begin
                case (off)
                    OFF_OUT:     out_q   <= wr_data;
                    OFF_DIR:     dir_q   <= wr_data;
                    OFF_RISE_EN: rise_en <= wr_data;
                    OFF_FALL_EN: fall_en <= wr_data;
                    OFF_SET:     out_q   <= out_q | wr_data;
                    OFF_CLR:     out_q   <= out_q & ~wr_data;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_IN:      rd_val = s2;
            OFF_OUT:     rd_val = out_q;
            OFF_DIR:     rd_val = dir_q;
            OFF_RISE_EN: rd_val = rise_en;
            OFF_FALL_EN: rd_val = fall_en;
            OFF_PEND:    rd_val = pend;
            default:     rd_val = '0;
        endcase
    end

    assign out_val  = out_q;
    assign dir_val  = dir_q;
    assign pend_any = |pend;

endmodule

// File: rtl/gpio_irq_bank.sv
// rtl/gpio_irq_bank.sv - memory-mapped GPIO bank with aggregated edge interrupt
module gpio_irq_bank
    import gpio_pkg::*;
#(
    parameter int               N_PORTS = 2,
    parameter int               WIDTH   = 8,
    parameter logic [ADDR_W-1:0] BASE   = 14'd16
) (
    input  logic                       clk,
    input  logic                       rst,
    gpio_irq_bank_if.slave             bus,
    input  logic [N_PORTS*WIDTH-1:0]   gpio_in,
    output logic [N_PORTS*WIDTH-1:0]   gpio_out,
    output logic [N_PORTS*WIDTH-1:0]   gpio_oe,
    output logic                       irq
);

    logic [N_PORTS-1:0] port_sel;
    logic [N_PORTS-1:0] pend_any;
    logic [WIDTH-1:0]   rd_vals [N_PORTS];
    logic [2:0]         off;
    logic               irq_stat_sel;
    logic [DATA_W-1:0]  rd_next;
    logic [DATA_W-1:0]  data_q;
    logic               irq_q;
    logic               unused_data;

    // port windows are 8-aligned relative to BASE, so the offset is the low bits of addr-BASE
    assign off          = bus.adresse[2:0] - BASE[2:0];
    assign irq_stat_sel = bus.CS && irq_stat_hit(bus.adresse, BASE, N_PORTS);
    assign unused_data  = ^bus.DATAout;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        assign port_sel[p] = bus.CS && port_hit(bus.adresse, BASE, p);

        gpio_port #(.WIDTH(WIDTH)) u_port (
            .clk      (clk),
            .rst      (rst),
            .pad      (gpio_in[p*WIDTH +: WIDTH]),
            .wr_en    (port_sel[p] && bus.write),
            .off      (off),
            .wr_data  (bus.DATAout[WIDTH-1:0]),
            .rd_val   (rd_vals[p]),
            .out_val  (gpio_out[p*WIDTH +: WIDTH]),
            .dir_val  (gpio_oe[p*WIDTH +: WIDTH]),
            .pend_any (pend_any[p])
        );
    end

    always_comb begin
        rd_next = '0;
        if (irq_stat_sel) begin
            rd_next[N_PORTS-1:0] = pend_any;
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (port_sel[i]) begin
                rd_next[WIDTH-1:0] = rd_vals[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            data_q <= (bus.CS && bus.read) ? rd_next : '0;
            irq_q  <= |pend_any;
        end
    end

    assign bus.DATAin = data_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_irq_bank.sv
// tb/tb_gpio_irq_bank.sv - scoreboard bench for gpio_irq_bank against a register-level model
module tb_gpio_irq_bank;
    localparam int          NP   = 2;
    localparam int          W    = 8;
    localparam int          NW   = NP * W;
    localparam logic [13:0] BASE = 14'd16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NW-1:0] gpio_in, gpio_out, gpio_oe;
    logic          irq;

    always #5 clk = ~clk;

    gpio_irq_bank_if bus ();

    gpio_irq_bank #(.N_PORTS(NP), .WIDTH(W), .BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    typedef struct packed {
        logic [15:0]   data;
        logic          irq;
        logic [NW-1:0] out;
        logic [NW-1:0] oe;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0]  m_out[NP], m_dir[NP], m_ren[NP], m_fen[NP], m_pend[NP];
    logic [NW-1:0] m_hist[3];   // pad as sampled at the last three edges, [0] newest

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [13:0] addr);
        int          a;
        logic [15:0] v;
        a = int'(addr) - int'(BASE);
        v = '0;
        if (a >= 0 && a < NP * 8) begin
            case (a % 8)
                0: v[W-1:0] = m_hist[1][(a/8)*W +: W];
                1: v[W-1:0] = m_out[a/8];
                2: v[W-1:0] = m_dir[a/8];
                3: v[W-1:0] = m_ren[a/8];
                4: v[W-1:0] = m_fen[a/8];
                5: v[W-1:0] = m_pend[a/8];
                default: v = '0;
            endcase
        end else if (a == NP * 8) begin
            for (int p = 0; p < NP; p++) v[p] = |m_pend[p];
        end
        return v;
    endfunction

    task automatic step(input logic r, input logic cs, input logic [13:0] addr,
                        input logic wr, input logic rd, input logic [15:0] d,
                        input logic [NW-1:0] pad);
        exp_t        e;
        int          a;
        logic [W-1:0] s2, pv, newp, clr, dw;
        rst = r; bus.CS = cs; bus.adresse = addr; bus.write = wr; bus.read = rd;
        bus.DATAout = d; gpio_in = pad;
        dw = d[W-1:0];
        if (r) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p] = '0; m_dir[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_pend[p] = '0;
            end
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            e.data = '0;
            e.irq  = 1'b0;
        end else begin
            e.data = (cs && rd) ? model_read(addr) : 16'h0;
            e.irq  = 1'b0;
            for (int p = 0; p < NP; p++) e.irq |= |m_pend[p];
            a = int'(addr) - int'(BASE);
            for (int p = 0; p < NP; p++) begin
                s2   = m_hist[1][p*W +: W];
                pv   = m_hist[2][p*W +: W];
                newp = (s2 & ~pv & m_ren[p]) | (~s2 & pv & m_fen[p]);
                clr  = '0;
                if (cs && wr && a >= 0 && a / 8 == p && a < NP * 8) begin
                    case (a % 8)
                        1: m_out[p] = dw;
                        2: m_dir[p] = dw;
                        3: m_ren[p] = dw;
                        4: m_fen[p] = dw;
                        5: clr = dw;
                        6: m_out[p] = m_out[p] | dw;
                        7: m_out[p] = m_out[p] & ~dw;
                        default: ;
                    endcase
                end
                m_pend[p] = (m_pend[p] & ~clr) | newp;
            end
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = pad;
        end
        for (int p = 0; p < NP; p++) begin
            e.out[p*W +: W] = m_out[p];
            e.oe[p*W +: W]  = m_dir[p];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [NW-1:0] pad);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 16'h0, pad);
    endtask

    task automatic wr_reg(input logic [13:0] addr, input logic [15:0] d, input logic [NW-1:0] pad);
        step(1'b0, 1'b1, addr, 1'b1, 1'b0, d, pad);
    endtask

    task automatic rd_reg(input logic [13:0] addr, input logic [NW-1:0] pad);
        step(1'b0, 1'b1, addr, 1'b0, 1'b1, 16'h0, pad);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check("DATAin", 64'(bus.DATAin), 64'(e.data));
            check("irq", 64'(irq), 64'(e.irq));
            check("gpio_out", 64'(gpio_out), 64'(e.out));
            check("gpio_oe", 64'(gpio_oe), 64'(e.oe));
        end
    end

    logic [NW-1:0] pad;

    initial begin
        pad = '1;
        // reset with pads high, then read every register
        step(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 16'h0, pad);
        step(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 16'h0, pad);
        for (int i = 0; i <= NP * 8; i++) rd_reg(BASE + 14'(i), pad);
        rd_reg(BASE, pad);

        // DIR/OUT/SET/CLR on port 0
        wr_reg(BASE + 14'd2, 16'hFF0F, pad);
        wr_reg(BASE + 14'd1, 16'h00A5, pad);
        wr_reg(BASE + 14'd6, 16'h0010, pad);
        wr_reg(BASE + 14'd7, 16'h0001, pad);
        rd_reg(BASE + 14'd1, pad);
        check("p0_oe", 64'(gpio_oe[7:0]), 64'h0F);
        check("p0_out", 64'(gpio_out[7:0]), 64'hB4);

        // rising edge on bit 8 with port 1 RISE_EN bit0
        pad = '0;
        idle(4, pad);
        wr_reg(BASE + 14'd11, 16'h0001, pad);
        pad[8] = 1'b1;
        idle(4, pad);
        check("irq_after_rise", 64'(irq), 64'h1);
        rd_reg(BASE + 14'(NP * 8), pad);
        rd_reg(BASE + 14'd13, pad);

        // fall on bit3 coinciding with W1C: set wins
        wr_reg(BASE + 14'd13, 16'h0001, pad);
        pad[3] = 1'b1;
        idle(3, pad);
        wr_reg(BASE + 14'd4, 16'h0008, pad);
        pad[3] = 1'b0;
        idle(2, pad);
        wr_reg(BASE + 14'd5, 16'h0008, pad);
        rd_reg(BASE + 14'd5, pad);
        wr_reg(BASE + 14'd5, 16'h0008, pad);
        idle(2, pad);
        rd_reg(BASE + 14'd5, pad);

        // unmapped and write-only reads, CS low writes
        rd_reg(BASE + 14'(NP * 8 + 1), pad);
        rd_reg(BASE + 14'd6, pad);
        step(1'b0, 1'b0, BASE + 14'd1, 1'b1, 1'b0, 16'h00FF, pad);
        step(1'b0, 1'b0, BASE + 14'd2, 1'b1, 1'b1, 16'h00FF, pad);
        wr_reg(BASE + 14'd0, 16'h00FF, pad);

        // reset while pending
        wr_reg(BASE + 14'd3, 16'h00FF, pad);
        pad[0] = 1'b1;
        idle(5, pad);
        step(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 16'h0, pad);
        check("irq_after_rst", 64'(irq), 64'h0);
        idle(4, pad);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, cs, wr, rd;
            logic [13:0] addr;
            r    = ($urandom_range(0, 299) == 0);
            cs   = ($urandom_range(0, 3) != 0);
            wr   = $urandom_range(0, 1) == 1;
            rd   = $urandom_range(0, 1) == 1;
            addr = BASE - 14'd2 + 14'($urandom_range(0, NP * 8 + 4));
            if ($urandom_range(0, 2) == 0) pad[$urandom_range(0, NW - 1)] ^= 1'b1;
            step(r, cs, addr, wr, rd, 16'($urandom), pad);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sbq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
